// File: rtl/reg_writeback.sv
// reg_writeback: in-order writeback queue between retiring instructions and
// the register file. Non-load entries retire one cycle after reaching the
// head. Load entries wait at the head for their in-order memory response.
// pend_mask tracks registers that a queued entry will still write.
module reg_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4:0]                in_dest,
    input  logic                      in_wb_en,
    input  logic                      in_is_load,
    input  logic [31:0]               in_alu_val,
    input  logic                      mem_rvalid,
    input  logic [31:0]               mem_rdata,
    output logic                      wr_en,
    output logic [4:0]                wr_dest,
    output logic [31:0]               wr_val,
    output logic [31:0]               pend_mask,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      err_orphan
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Decode a register index into a 32-bit one-hot mask.
    function automatic logic [31:0] onehot(input logic [4:0] d);
        logic [31:0] r;
        r    = 32'd0;
        r[d] = 1'b1;
        return r;
    endfunction

    // Distance of slot i from the head, wrapped to the pointer width.
    function automatic logic [PTR_W-1:0] rel_idx(input int i, input logic [PTR_W-1:0] h);
        logic [PTR_W-1:0] t;
        t = PTR_W'(i);
        return t - h;
    endfunction

    // Queue storage; validity is carried entirely by head/count, so the
    // payload needs no reset.
    logic [4:0]  dest_q [DEPTH];
    logic        wb_q   [DEPTH];
    logic        ld_q   [DEPTH];
    logic [31:0] val_q  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en_q, wr_en_d;
    logic [4:0]       wr_dest_q, wr_dest_d;
    logic [31:0]      wr_val_q, wr_val_d;
    logic             err_q, err_d;

    logic        push_s;
    logic        retire_s;
    logic        nonempty_s;
    logic        head_ld_s;
    logic        orphan_s;
    logic [31:0] pend_s;

    // Handshake and head-of-queue decisions. in_ready comes only from the
    // registered count, so a retire never frees a slot in the same cycle.
    always_comb begin
        nonempty_s = (count_q != CNT_W'(0));
        head_ld_s  = ld_q[head_q];
        in_ready   = (count_q != CNT_W'(DEPTH));
        push_s     = in_valid && in_ready;
        retire_s   = nonempty_s && (!head_ld_s || mem_rvalid);
        orphan_s   = mem_rvalid && (!nonempty_s || !head_ld_s);
    end

    // Next-state for pointers, count, writeback port and sticky orphan flag.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_dest_d = wr_dest_q;
        wr_val_d  = wr_val_q;
        err_d     = err_q;

        if (push_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end

        if (retire_s) begin
            head_d    = head_q + PTR_W'(1);
            wr_en_d   = wb_q[head_q] && (dest_q[head_q] != 5'd0);
            wr_dest_d = dest_q[head_q];
            wr_val_d  = ld_q[head_q] ? mem_rdata : val_q[head_q];
        end else begin
            head_d    = head_q;
        end

        if (push_s && !retire_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_s && retire_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end

        if (orphan_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Control state register with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= {PTR_W{1'b0}};
            tail_q    <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            wr_en_q   <= 1'b0;
            wr_dest_q <= 5'd0;
            wr_val_q  <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_val_q  <= wr_val_d;
            err_q     <= err_d;
        end
    end

    // Payload write at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            dest_q[tail_q] <= in_dest;
            wb_q[tail_q]   <= in_wb_en;
            ld_q[tail_q]   <= in_is_load;
            val_q[tail_q]  <= in_alu_val;
        end
    end

    // Registers still owed a write by a queued entry. A retired entry has
    // already been popped, so the one on wr_* is excluded automatically.
    always_comb begin
        pend_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, rel_idx(i, head_q)} < count_q) && wb_q[i] && (dest_q[i] != 5'd0)) begin
                pend_s = pend_s | onehot(dest_q[i]);
            end else begin
                pend_s = pend_s;
            end
        end
    end

    assign pend_mask  = pend_s;
    assign occupancy  = count_q;
    assign wr_en      = wr_en_q;
    assign wr_dest    = wr_dest_q;
    assign wr_val     = wr_val_q;
    assign err_orphan = err_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback (DEPTH=4). Inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_dest;
    logic        in_wb_en;
    logic        in_is_load;
    logic [31:0] in_alu_val;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wr_en;
    logic [4:0]  wr_dest;
    logic [31:0] wr_val;
    logic [31:0] pend_mask;
    logic [2:0]  occupancy;
    logic        err_orphan;

    int compared   = 0;
    int mismatched = 0;

    reg_writeback #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dest(in_dest), .in_wb_en(in_wb_en), .in_is_load(in_is_load),
        .in_alu_val(in_alu_val),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wr_en(wr_en), .wr_dest(wr_dest), .wr_val(wr_val),
        .pend_mask(pend_mask), .occupancy(occupancy), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] d, input logic wb, input logic ld, input logic [31:0] v);
        in_valid   = 1'b1;
        in_dest    = d;
        in_wb_en   = wb;
        in_is_load = ld;
        in_alu_val = v;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_dest = 5'd0; in_wb_en = 1'b0;
        in_is_load = 1'b0; in_alu_val = 32'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_dest", 32'(wr_dest), 32'd0);
        chk("rst_wr_val", wr_val, 32'd0);
        chk("rst_pend", pend_mask, 32'd0);
        chk("rst_err", 32'(err_orphan), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Basic non-load latency
        push(5'd5, 1'b1, 1'b0, 32'h1234);
        tick(); in_valid = 1'b0;
        chk("nl_pend", pend_mask, 32'h20);
        chk("nl_occ", 32'(occupancy), 32'd1);
        chk("nl_wr_en0", 32'(wr_en), 32'd0);
        tick();
        chk("nl_wr_en", 32'(wr_en), 32'd1);
        chk("nl_wr_dest", 32'(wr_dest), 32'd5);
        chk("nl_wr_val", wr_val, 32'h1234);
        chk("nl_pend_clr", pend_mask, 32'd0);
        tick();
        chk("nl_wr_en_off", 32'(wr_en), 32'd0);
        chk("nl_dest_hold", 32'(wr_dest), 32'd5);
        chk("nl_val_hold", wr_val, 32'h1234);

        // Load blocks a younger non-load until its response arrives
        push(5'd3, 1'b1, 1'b1, 32'h99);
        tick();
        push(5'd4, 1'b1, 1'b0, 32'd7);
        tick(); in_valid = 1'b0;
        chk("ld_occ", 32'(occupancy), 32'd2);
        for (int i = 0; i < 5; i++) begin
            chk("ld_wait_pend", pend_mask, 32'h18);
            chk("ld_wait_wr_en", 32'(wr_en), 32'd0);
            tick();
        end
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE;
        tick(); mem_rvalid = 1'b0; mem_rdata = 32'd0;
        chk("ld_wr_en", 32'(wr_en), 32'd1);
        chk("ld_wr_dest", 32'(wr_dest), 32'd3);
        chk("ld_wr_val", wr_val, 32'hCAFE);
        chk("ld_pend", pend_mask, 32'h10);
        tick();
        chk("ld2_wr_en", 32'(wr_en), 32'd1);
        chk("ld2_wr_dest", 32'(wr_dest), 32'd4);
        chk("ld2_wr_val", wr_val, 32'd7);
        chk("ld2_pend", pend_mask, 32'd0);
        tick();
        chk("ld_wr_en_off", 32'(wr_en), 32'd0);
        chk("ld_no_err", 32'(err_orphan), 32'd0);

        // Same-edge push and retire keeps occupancy
        push(5'd1, 1'b1, 1'b0, 32'h11);
        tick();
        push(5'd2, 1'b1, 1'b0, 32'h22);
        tick(); in_valid = 1'b0;
        chk("same_occ", 32'(occupancy), 32'd1);
        chk("same_wr_dest", 32'(wr_dest), 32'd1);
        chk("same_wr_val", wr_val, 32'h11);
        chk("same_pend", pend_mask, 32'h4);
        tick();
        chk("same2_wr_dest", 32'(wr_dest), 32'd2);
        chk("same2_wr_val", wr_val, 32'h22);
        chk("same2_occ", 32'(occupancy), 32'd0);

        // Fill with loads, then free one slot
        for (int i = 0; i < 4; i++) begin
            push(5'(8 + i), 1'b1, 1'b1, 32'd0);
            tick();
        end
        push(5'd12, 1'b1, 1'b0, 32'hDEAD);
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_pend", pend_mask, 32'h0F00);
        mem_rvalid = 1'b1; mem_rdata = 32'hA8;
        tick(); in_valid = 1'b0;
        chk("free_occ", 32'(occupancy), 32'd3);
        chk("free_ready", 32'(in_ready), 32'd1);
        chk("free_wr_dest", 32'(wr_dest), 32'd8);
        chk("free_wr_val", wr_val, 32'hA8);
        chk("free_pend", pend_mask, 32'h0E00);
        for (int i = 0; i < 3; i++) begin
            mem_rdata = 32'(32'hA9 + i);
            tick();
            chk("drain_wr_dest", 32'(wr_dest), 32'(9 + i));
            chk("drain_wr_val", wr_val, 32'(32'hA9 + i));
        end
        mem_rvalid = 1'b0;
        chk("drain_occ", 32'(occupancy), 32'd0);
        chk("drain_err", 32'(err_orphan), 32'd0);

        // Load without writeback still consumes its response
        push(5'd6, 1'b0, 1'b1, 32'd0);
        tick(); in_valid = 1'b0;
        chk("nowb_pend", pend_mask, 32'd0);
        tick();
        chk("nowb_wait_occ", 32'(occupancy), 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'd5;
        tick(); mem_rvalid = 1'b0;
        chk("nowb_wr_en", 32'(wr_en), 32'd0);
        chk("nowb_wr_dest", 32'(wr_dest), 32'd6);
        chk("nowb_wr_val", wr_val, 32'd5);
        chk("nowb_occ", 32'(occupancy), 32'd0);
        chk("nowb_err", 32'(err_orphan), 32'd0);

        // Write to register 0
        push(5'd0, 1'b1, 1'b0, 32'hFFFF);
        tick(); in_valid = 1'b0;
        chk("r0_pend", pend_mask, 32'd0);
        chk("r0_occ", 32'(occupancy), 32'd1);
        tick();
        chk("r0_wr_en", 32'(wr_en), 32'd0);
        chk("r0_wr_val", wr_val, 32'hFFFF);
        chk("r0_occ_after", 32'(occupancy), 32'd0);

        // Reset with three entries in flight, push and response also offered
        for (int i = 0; i < 3; i++) begin
            push(5'(20 + i), 1'b1, 1'b1, 32'd0);
            tick();
        end
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        tick();
        rst = 1'b0; in_valid = 1'b0; mem_rvalid = 1'b0;
        chk("r2_occ", 32'(occupancy), 32'd0);
        chk("r2_pend", pend_mask, 32'd0);
        chk("r2_wr_en", 32'(wr_en), 32'd0);
        chk("r2_wr_dest", 32'(wr_dest), 32'd0);
        chk("r2_ready", 32'(in_ready), 32'd1);
        chk("r2_err", 32'(err_orphan), 32'd0);

        // Orphan response on empty queue
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        tick(); mem_rvalid = 1'b0;
        chk("orph_err", 32'(err_orphan), 32'd1);
        chk("orph_wr_en", 32'(wr_en), 32'd0);
        chk("orph_occ", 32'(occupancy), 32'd0);
        tick(); tick();
        chk("orph_sticky", 32'(err_orphan), 32'd1);

        // Orphan response with a non-load head: head still retires
        push(5'd7, 1'b1, 1'b0, 32'h77);
        tick(); in_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1;
        tick(); mem_rvalid = 1'b0;
        chk("orph_nl_wr_en", 32'(wr_en), 32'd1);
        chk("orph_nl_wr_dest", 32'(wr_dest), 32'd7);
        chk("orph_nl_wr_val", wr_val, 32'h77);
        chk("orph_nl_occ", 32'(occupancy), 32'd0);

        // Reset clears the sticky flag
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("err_cleared", 32'(err_orphan), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
